apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS wait cycles; range 1..255.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request offered.
REQ-008 req_ready  out  1  request buffer can accept.
REQ-009 req_write  in  1  1=write, 0=read.
REQ-010 req_id  in  2  target slave ID; 0 reserved (no slave).
REQ-011 req_addr  in  ADDR_W  transfer address.
REQ-012 req_wdata  in  DATA_W  write data.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-015 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-016 apb_sel  out  2  slave ID select, 0=idle bus.
REQ-017 apb_enable  out  1  ACCESS phase marker.
REQ-018 apb_write  out  1  transfer direction.
REQ-019 apb_addr  out  ADDR_W  bus address.
REQ-020 apb_wdata  out  DATA_W  bus write data.
REQ-021 apb_rdata  in  DATA_W  slave read data.
REQ-022 apb_ready  in  1  slave completion.

Function
REQ-023 SHALL buffer requests in a 2-entry FIFO; push when req_valid && req_ready; req_ready = !full.
REQ-024 SHALL block a push while the FIFO is full, even in a cycle where a pop occurs.
REQ-025 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-026 IDLE with FIFO non-empty: SHALL pop the head; id!=0 -> SETUP; id==0 -> stay IDLE and pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle, with no bus activity.
REQ-027 SETUP (one cycle): SHALL drive apb_sel=id, apb_write, apb_addr, apb_wdata, and apb_enable=0; then go to ACCESS.
REQ-028 ACCESS: SHALL drive apb_enable=1 and hold sel, addr, wdata and write stable until apb_ready is sampled 1.
REQ-029 On ACCESS with apb_ready=1: SHALL capture apb_rdata (reads) or 0 (writes) and pulse rsp_valid with rsp_err=0 on the next cycle.
REQ-030 After ACCESS completes: SHALL go to SETUP with the popped FIFO head if one is valid, else IDLE with apb_sel=0 and apb_enable=0.
REQ-031 Minimum latency: SHALL pulse rsp_valid 3 cycles after the accepting push (pop, SETUP, ACCESS with apb_ready=1).
REQ-032 rsp_valid SHALL have no backpressure; at most one pulse per request, in request order.

Reset
REQ-033 While reset=1: SHALL set state=IDLE, empty the FIFO, and drive req_ready=0 and every other output to 0.
REQ-034 req_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no rsp_valid and the bus idle on the next cycle.

Configuration
REQ-036 With macro APB_MASTER_TIMEOUT_EN defined: SHALL load an 8-bit counter with TIMEOUT_CYCLES on entry to ACCESS and decrement it each ACCESS cycle with apb_ready=0.
REQ-037 When that counter reaches 0 with apb_ready=0: SHALL abort, drop apb_sel and apb_enable next cycle, and pulse rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-038 Without APB_MASTER_TIMEOUT_EN: SHALL wait in ACCESS indefinitely; rsp_err=1 only for id==0.

Structure
REQ-039 Package apb_pkg SHALL hold the FSM state typedef, the slave ID constants (ID_NONE=0, ID_1..ID_3), and the default width constants.
REQ-040 The FIFO SHALL be a sub-module apb_req_fifo (2-deep, parameterised width); no other sub-modules.

Verification
REQ-041 Write id=1, addr=0x10, wdata=0xA5, apb_ready tied 1 -> SETUP sel=1/enable=0, then ACCESS enable=1, then rsp_valid, rsp_err=0; bus idle after.
REQ-042 Read id=2, addr=0x20, slave returns 0x3C after 3 wait cycles -> addr stable through ACCESS, rsp_rdata=0x3C, rsp_err=0.
REQ-043 Three back-to-back pushes with apb_ready=0 -> req_ready=0 after 2 queued; transfers then run SETUP/ACCESS back-to-back in order.
REQ-044 Request with id=0 -> apb_sel stays 0; rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-045 APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, apb_ready held 0 -> abort after 4 ACCESS cycles, rsp_err=1; next request proceeds normally.
REQ-046 Assert reset during ACCESS -> next cycle all outputs 0, FIFO empty, no rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master: FSM state encoding,
// slave ID values and default widths.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_1    = 2'd1;
  localparam logic [1:0] ID_2    = 2'd2;
  localparam logic [1:0] ID_3    = 2'd3;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/apb_req_fifo.sv
// Two-entry request buffer. A push is refused while full, even in a pop cycle.
module apb_req_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_next_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign empty_o     = (cnt_q == 2'd0);
  assign full_next_o = (cnt_d == 2'd2);

endmodule

// File: rtl/apb_master.sv
// APB master: buffered requests driven through IDLE/SETUP/ACCESS, all outputs registered.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master import apb_pkg::*; #(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_id,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        apb_sel,
  output logic              apb_enable,
  output logic              apb_write,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_wdata,
  input  logic [DATA_W-1:0] apb_rdata,
  input  logic              apb_ready
);

  localparam int REQ_W = 1 + 2 + ADDR_W + DATA_W;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
    $error("apb_master: TIMEOUT_CYCLES must be within 1..255");
  end

  logic [REQ_W-1:0]  fifo_head;
  logic              fifo_empty, fifo_full_next, fifo_push, fifo_pop;
  logic              head_write;
  logic [1:0]        head_id;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  apb_state_e        state_q, state_d;
  logic              req_ready_q;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        sel_q, sel_d;
  logic              enable_q, enable_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              load_head;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES);
  logic [7:0]        tmo_q, tmo_d;
`endif

  assign fifo_push = req_valid && req_ready_q;
  assign {head_write, head_id, head_addr, head_wdata} = fifo_head;

  apb_req_fifo #(.WIDTH(REQ_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i ({req_write, req_id, req_addr, req_wdata}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_next_o (fifo_full_next)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    enable_d    = enable_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    fifo_pop    = 1'b0;
    load_head   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sel_d    = ID_NONE;
        enable_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          // Requests to the reserved ID complete with an error and never reach the bus.
          if (head_id == ID_NONE) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            load_head = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        enable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_d    = TMO_LOAD;
`endif
      end
      ST_ACCESS: begin
        if (apb_ready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : apb_rdata;
          // An ID-0 head is left for IDLE so its error pulse cannot collide with this one.
          if (!fifo_empty && head_id != ID_NONE) begin
            fifo_pop  = 1'b1;
            load_head = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            sel_d    = ID_NONE;
            enable_d = 1'b0;
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_q <= 8'd1) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
          sel_d       = ID_NONE;
          enable_d    = 1'b0;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_head) begin
      state_d  = ST_SETUP;
      sel_d    = head_id;
      enable_d = 1'b0;
      write_d  = head_write;
      addr_d   = head_addr;
      wdata_d  = head_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      sel_q       <= ID_NONE;
      enable_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= !fifo_full_next;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      sel_q       <= sel_d;
      enable_q    <= enable_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= 8'd0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign apb_sel    = sel_q;
  assign apb_enable = enable_q;
  assign apb_write  = write_q;
  assign apb_addr   = addr_q;
  assign apb_wdata  = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed bus-timing steps, then random traffic checked
// against an in-order request/response model with a randomly stalling slave.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [1:0]    req_id;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    apb_sel;
  logic          apb_enable, apb_write;
  logic [AW-1:0] apb_addr;
  logic [DW-1:0] apb_wdata, apb_rdata;
  logic          apb_ready;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_id     (req_id),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_sel    (apb_sel),
    .apb_enable (apb_enable),
    .apb_write  (apb_write),
    .apb_addr   (apb_addr),
    .apb_wdata  (apb_wdata),
    .apb_rdata  (apb_rdata),
    .apb_ready  (apb_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [1:0] id;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  int         total = 0;
  int         bad   = 0;
  req_t       bus_q[$];
  req_t       rsp_q[$];
  logic [7:0] done_q[$];
  req_t       cur;
  int         wait_left = 0;
  bit         rand_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] id, input logic [7:0] addr,
                       input logic [7:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_id    = id;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // Model: every accepted request answers once, in order; non-zero IDs appear
  // on the bus in order, ID 0 never does. The slave stalls 0..3 cycles.
  task automatic monitor();
    req_t       e;
    logic [7:0] r;
    if (apb_sel != 2'd0 && !apb_enable) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", {30'd0, apb_sel}, 32'd0);
      end else begin
        cur = bus_q.pop_front();
        chk("rand_setup", {apb_sel, apb_write, apb_addr, apb_wdata},
            {cur.id, cur.wr, cur.addr, cur.wdata});
        wait_left = $urandom_range(0, 3);
      end
    end
    if (apb_enable)
      chk("rand_access_stable", {apb_sel, apb_write, apb_addr, apb_wdata},
          {cur.id, cur.wr, cur.addr, cur.wdata});
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        r = 8'd0;
        if (e.id != 2'd0) begin
          if (done_q.size() == 0) chk("rsp_before_bus", {31'd0, rsp_valid}, 32'd0);
          else r = done_q.pop_front();
        end
        chk("rand_rsp", {rsp_err, rsp_rdata}, {(e.id == 2'd0), r});
      end
    end
    if (apb_enable) begin
      apb_rdata = 8'($urandom);
      if (wait_left == 0) begin
        apb_ready = 1'b1;
        done_q.push_back(cur.wr ? 8'd0 : apb_rdata);
      end else begin
        apb_ready = 1'b0;
        wait_left--;
      end
    end else begin
      apb_ready = 1'($urandom);
      apb_rdata = 8'($urandom);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rand_on) monitor();
  endtask

  initial begin
    req_t e;
    bit   acc;
    int   n_acc;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_id = 2'd0;
    req_addr = '0; req_wdata = '0; apb_rdata = '0; apb_ready = 1'b0;

    // Reset values
    repeat (3) cycle();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_bus", {apb_sel, apb_enable, apb_write, apb_addr, apb_wdata}, 32'd0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    reset = 1'b0;
    cycle();
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Write, zero wait states
    apb_ready = 1'b1;
    drive(1'b1, 2'd1, 8'h10, 8'hA5);
    cycle(); req_valid = 1'b0;
    chk("w_pushed", {apb_sel, rsp_valid}, 32'd0);
    cycle();
    chk("w_setup", {apb_sel, apb_enable, apb_write, apb_addr, apb_wdata},
        {2'd1, 1'b0, 1'b1, 8'h10, 8'hA5});
    cycle();
    chk("w_access", {apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, rsp_valid},
        {2'd1, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0});
    cycle();
    chk("w_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    chk("w_idle", {apb_sel, apb_enable}, 32'd0);
    cycle();
    chk("w_rsp_once", {31'd0, rsp_valid}, 32'd0);

    // Read with three wait states
    apb_ready = 1'b0; apb_rdata = 8'h55;
    drive(1'b0, 2'd2, 8'h20, 8'h00);
    cycle(); req_valid = 1'b0;
    cycle();
    chk("r_setup", {apb_sel, apb_enable, apb_write, apb_addr}, {2'd2, 1'b0, 1'b0, 8'h20});
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("r_access_hold", {apb_sel, apb_enable, apb_addr, rsp_valid}, {2'd2, 1'b1, 8'h20, 1'b0});
    end
    apb_ready = 1'b1; apb_rdata = 8'h3C;
    cycle();
    chk("r_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h3C});
    chk("r_idle", {apb_sel, apb_enable}, 32'd0);

    // Reserved ID 0
    drive(1'b0, 2'd0, 8'h30, 8'h00);
    cycle(); req_valid = 1'b0;
    chk("id0_pushed", {apb_sel, rsp_valid}, 32'd0);
    cycle();
    chk("id0_rsp", {rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable},
        {1'b1, 1'b1, 8'h00, 2'd0, 1'b0});
    cycle();
    chk("id0_once", {apb_sel, apb_enable, rsp_valid}, 32'd0);

    // Three back-to-back pushes against a stalled slave
    apb_ready = 1'b0; apb_rdata = 8'h00;
    drive(1'b1, 2'd1, 8'h01, 8'h11);
    cycle(); chk("bb_ready_a", {31'd0, req_ready}, 32'd1);
    drive(1'b1, 2'd2, 8'h02, 8'h22);
    cycle(); chk("bb_ready_b", {31'd0, req_ready}, 32'd1);
    chk("bb_setup_a", {apb_sel, apb_enable, apb_addr}, {2'd1, 1'b0, 8'h01});
    drive(1'b1, 2'd3, 8'h03, 8'h33);
    cycle(); req_valid = 1'b0;
    chk("bb_full", {31'd0, req_ready}, 32'd0);
    chk("bb_access_a", {apb_sel, apb_enable}, {2'd1, 1'b1});
    cycle(); chk("bb_still_full", {31'd0, req_ready}, 32'd0);
    apb_ready = 1'b1;
    cycle();
    chk("bb_rsp_a", {rsp_valid, rsp_err}, {1'b1, 1'b0});
    chk("bb_setup_b", {apb_sel, apb_enable, apb_addr, apb_wdata, req_ready},
        {2'd2, 1'b0, 8'h02, 8'h22, 1'b1});
    cycle(); chk("bb_access_b", {apb_sel, apb_enable, rsp_valid}, {2'd2, 1'b1, 1'b0});
    cycle();
    chk("bb_rsp_b", {rsp_valid, rsp_err}, {1'b1, 1'b0});
    chk("bb_setup_c", {apb_sel, apb_enable, apb_addr, apb_wdata}, {2'd3, 1'b0, 8'h03, 8'h33});
    cycle(); chk("bb_access_c", {apb_sel, apb_enable}, {2'd3, 1'b1});
    cycle();
    chk("bb_rsp_c", {rsp_valid, rsp_err, apb_sel, apb_enable}, {1'b1, 1'b0, 2'd0, 1'b0});

`ifdef APB_MASTER_TIMEOUT_EN
    // ACCESS timeout after four unanswered cycles
    apb_ready = 1'b0; apb_rdata = 8'h77;
    drive(1'b0, 2'd1, 8'h44, 8'h00);
    cycle(); req_valid = 1'b0;
    cycle(); chk("to_setup", {apb_sel, apb_enable}, {2'd1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("to_access", {apb_sel, apb_enable, rsp_valid}, {2'd1, 1'b1, 1'b0});
    end
    cycle();
    chk("to_abort", {rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable},
        {1'b1, 1'b1, 8'h00, 2'd0, 1'b0});
    apb_ready = 1'b1;
    drive(1'b1, 2'd3, 8'h45, 8'h5A);
    cycle(); req_valid = 1'b0;
    cycle(); chk("to_next_setup", {apb_sel, apb_enable, apb_addr}, {2'd3, 1'b0, 8'h45});
    cycle(); cycle();
    chk("to_next_rsp", {rsp_valid, rsp_err}, {1'b1, 1'b0});
`endif

    // Reset in the middle of ACCESS, with a second request queued
    apb_ready = 1'b0; apb_rdata = 8'h99;
    drive(1'b0, 2'd2, 8'h60, 8'h00);
    cycle();
    drive(1'b1, 2'd3, 8'h61, 8'h61);
    cycle(); req_valid = 1'b0;
    cycle();
    chk("mid_in_access", {apb_sel, apb_enable}, {2'd2, 1'b1});
    reset = 1'b1;
    cycle();
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_bus", {apb_sel, apb_enable, apb_write, apb_addr, apb_wdata}, 32'd0);
    chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    reset = 1'b0; apb_ready = 1'b1;
    cycle();
    chk("mid_rel", {req_ready, rsp_valid, apb_sel}, {1'b1, 1'b0, 2'd0});
    cycle(); cycle();
    chk("mid_fifo_empty", {apb_sel, apb_enable, rsp_valid}, 32'd0);

    // Random traffic against the model
    rand_on = 1'b1; acc = 1'b0; n_acc = 0;
    for (int cyc = 0; cyc < 4000 && n_acc < 80; cyc++) begin
      cycle();
      if (!req_valid || acc) begin
        acc       = 1'b0;
        req_valid = ($urandom_range(0, 3) != 0);
        req_id    = 2'($urandom);
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
      end
      if (req_valid && req_ready) begin
        e.wr = req_write; e.id = req_id; e.addr = req_addr; e.wdata = req_wdata;
        rsp_q.push_back(e);
        if (req_id != 2'd0) bus_q.push_back(e);
        acc = 1'b1;
        n_acc++;
      end
    end
    cycle();
    req_valid = 1'b0;
    for (int k = 0; k < 400 && rsp_q.size() != 0; k++) cycle();
    chk("rand_drain_rsp", rsp_q.size(), 32'd0);
    chk("rand_drain_bus", bus_q.size(), 32'd0);
    chk("rand_accepted", (n_acc >= 80) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
